// File: rtl/imem_responder.sv
// Instruction-memory responder: latches a fetch request, waits WAIT_STATES cycles, returns one word.
// Optional next-word prefetch tag enabled by defining IMEM_PREFETCH_EN.
module imem_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr_in,
  output logic [31:0] data,
  output logic        data_already,
  output logic        busy,
  output logic        addr_fault,
  output logic        misalign,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        dav_q, dav_d;
  logic        fault_q, fault_d;
  logic        mis_q, mis_d;
  logic        accept;
  logic        hit;
  logic [31:0] mem [DEPTH];
  logic        unused_lo;

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] widx(input logic [31:0] a);
    return a[DEPTH_LOG2+1:2];
  endfunction

  assign unused_lo = ^load_addr[1:0];

  // Program RAM: not cleared by reset; out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (load_we && in_range(load_addr)) mem[widx(load_addr)] <= load_data;
  end

`ifdef IMEM_PREFETCH_EN
  // The buffered word is kept coherent with RAM by invalidation, so a hit only
  // shortens latency; the response itself still reads RAM at the same address.
  logic        pf_vld_q, pf_vld_d;
  logic [29:0] pf_word_q, pf_word_d;
  logic [29:0] next_word;
  logic        load_hits_pf;

  assign next_word    = addr_q[31:2] + 30'd1;
  assign load_hits_pf = load_we && (load_addr[31:2] == pf_word_q);
  assign hit          = pf_vld_q && !load_hits_pf && (addr_in[31:2] == pf_word_q);

  always_comb begin
    pf_vld_d  = pf_vld_q && !load_hits_pf;
    pf_word_d = pf_word_q;
    if (state_q == RESP) begin
      pf_word_d = next_word;
      pf_vld_d  = ((next_word >> DEPTH_LOG2) == 30'd0) &&
                  !(load_we && (load_addr[31:2] == next_word));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_vld_q  <= 1'b0;
      pf_word_q <= '0;
    end else begin
      pf_vld_q  <= pf_vld_d;
      pf_word_q <= pf_word_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign accept = req && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = '0;
    dav_d   = 1'b0;
    fault_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        dav_d   = 1'b1;
        fault_d = !in_range(addr_q);
        mis_d   = |addr_q[1:0];
        data_d  = in_range(addr_q) ? mem[widx(addr_q)] : NOP_WORD;
        state_d = IDLE;
      end
      default: ;
    endcase
    // Acceptance in RESP overrides the return to IDLE for back-to-back fetches.
    if (accept) begin
      addr_d  = addr_in;
      cnt_d   = 4'(WAIT_STATES);
      state_d = (hit || WAIT_STATES == 0) ? RESP : WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dav_q   <= 1'b0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dav_q   <= dav_d;
      fault_q <= fault_d;
      mis_q   <= mis_d;
    end
  end

  assign data         = data_q;
  assign data_already = dav_q;
  assign addr_fault   = fault_q;
  assign misalign     = mis_q;
  assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (2 and 0 wait states) share one stimulus stream
// and are compared every cycle against a transaction-level timing/RAM model.
module tb_imem_responder;

  localparam int          DL  = 10;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk, reset, req, load_we;
  logic [31:0] addr_in, load_addr, load_data;
  logic [31:0] dout [2];
  logic        dav [2];
  logic        bsy [2];
  logic        flt [2];
  logic        mis [2];

  imem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(W0), .NOP_WORD(NOP)) u0 (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
    .data(dout[0]), .data_already(dav[0]), .busy(bsy[0]),
    .addr_fault(flt[0]), .misalign(mis[0]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  imem_responder #(.DEPTH_LOG2(DL), .WAIT_STATES(W1), .NOP_WORD(NOP)) u1 (
    .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
    .data(dout[1]), .data_already(dav[1]), .busy(bsy[1]),
    .addr_fault(flt[1]), .misalign(mis[1]),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: outstanding transaction per instance, RAM image, prefetch tag.
  logic [31:0] ram [1 << DL];
  bit          pend_v [2];
  int          pend_e [2];
  logic [31:0] pend_a [2];
  bit          pf_v [2];
  logic [29:0] pf_w [2];
  logic [31:0] e_data [2];
  bit          e_dav [2], e_flt [2], e_mis [2], e_bsy [2];
  int          lat [2];

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s[u%0d] cyc=%0d got=%h exp=%h", tag, inst, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("data", i, dout[i], e_data[i]);
      chk("data_already", i, {31'd0, dav[i]}, {31'd0, e_dav[i]});
      chk("busy", i, {31'd0, bsy[i]}, {31'd0, e_bsy[i]});
      chk("addr_fault", i, {31'd0, flt[i]}, {31'd0, e_flt[i]});
      chk("misalign", i, {31'd0, mis[i]}, {31'd0, e_mis[i]});
    end
  endtask

  // Advance the model across the coming edge, take the edge, then compare.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      bit          resp, busy_before, old_ok, hit;
      logic [29:0] old_w;
      logic [31:0] a;
      busy_before = pend_v[i];
      resp   = pend_v[i] && (pend_e[i] == cyc);
      old_w  = pf_w[i];
      old_ok = pf_v[i] && !(load_we && load_addr[31:2] == old_w);
      e_dav[i] = 1'b0; e_data[i] = '0; e_flt[i] = 1'b0; e_mis[i] = 1'b0;
      pf_v[i] = old_ok;
      if (resp) begin
        a = pend_a[i];
        e_dav[i]  = 1'b1;
        e_flt[i]  = (a >> (DL + 2)) != 0;
        e_mis[i]  = a[1:0] != 2'b00;
        e_data[i] = e_flt[i] ? NOP : ram[a[DL+1:2]];
        pend_v[i] = 1'b0;
        pf_w[i]   = a[31:2] + 30'd1;
        pf_v[i]   = ((pf_w[i] >> DL) == 0) && !(load_we && load_addr[31:2] == pf_w[i]);
      end
      if (req && (!busy_before || resp)) begin
        hit = PF && old_ok && (addr_in[31:2] == old_w);
        pend_v[i] = 1'b1;
        pend_a[i] = addr_in;
        pend_e[i] = cyc + (hit ? 1 : lat[i] + 1);
      end
      e_bsy[i] = pend_v[i] && (pend_e[i] - cyc > 1);
    end
    if (load_we) ram[load_addr[DL+1:2]] = load_data;
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pf_v[i] = 1'b0;
      e_dav[i] = 1'b0; e_data[i] = '0; e_flt[i] = 1'b0; e_mis[i] = 1'b0; e_bsy[i] = 1'b0;
    end
    check_all();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    req = 1'b0; load_we = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic fetch1(input logic [31:0] a);
    req = 1'b1; addr_in = a; load_we = 1'b0;
    step();
    req = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d; req = 1'b0;
    step();
    load_we = 1'b0;
  endtask

  initial begin
    lat[0] = W0; lat[1] = W1;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_e[i] = 0; pend_a[i] = '0; pf_v[i] = 1'b0; pf_w[i] = '0;
      e_dav[i] = 1'b0; e_data[i] = '0; e_flt[i] = 1'b0; e_mis[i] = 1'b0; e_bsy[i] = 1'b0;
    end
    reset = 1'b0; req = 1'b0; addr_in = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
    #1;
    check_all();
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    for (int w = 0; w < 33; w++) load(w * 4, 32'hA500_0000 | (w * 32'h1111));
    load(32'h10, 32'hDEADBEEF);

    // Single fetch with full latency, then out-of-range and misaligned fetches.
    fetch1(32'h10);
    idle(4);
    fetch1(32'h0000_1000);
    idle(4);
    fetch1(32'h12);
    req = 1'b1; addr_in = 32'h40;
    step();
    idle(4);

    // Sustained requests over consecutive words.
    req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      addr_in = k * 4;
      step();
    end
    idle(4);

    // Reset in the middle of a wait.
    fetch1(32'h8);
    apply_reset();
    idle(4);

    // Next-word fetch, then a load to the next word between fetches.
    fetch1(32'h20);
    idle(4);
    fetch1(32'h24);
    idle(4);
    fetch1(32'h20);
    idle(4);
    load(32'h24, 32'h1234_5678);
    fetch1(32'h24);
    idle(4);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      req = ($urandom_range(0, 1) == 1);
      if (r == 0)      addr_in = 32'h0000_1000 | ($urandom_range(0, 31) * 4);
      else if (r == 1) addr_in = 32'h8000_0000 | $urandom_range(0, 127);
      else             addr_in = $urandom_range(0, 127);
      load_we = ($urandom_range(0, 7) == 0);
      load_addr = $urandom_range(0, 127);
      load_data = $urandom;
      step();
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
